// File: rtl/v_elem_valid_gen_if.sv
// Issue-side bundle for the per-lane element-valid generator: instruction
// capture, row shifting and partial-chain control, plus the per-lane flags.
interface v_elem_valid_gen_if #(
    parameter int VLANE_NUM       = 8,
    parameter int MAX_VL_PER_LANE = 256
);
    localparam int VL_W = $clog2(VLANE_NUM * MAX_VL_PER_LANE) + 1;

    logic                 load_i;
    logic [VL_W-1:0]      vl_i;
    logic [VL_W-1:0]      vstart_i;
    logic                 vm_i;
    logic                 shift_en_i;
    logic [VLANE_NUM-1:0] mask_i;
    logic                 shift_partial_i;

    logic [VLANE_NUM-1:0] valid_o;
    logic [VLANE_NUM-1:0] tail_o;
    logic                 last_o;
    logic                 busy_o;
    logic                 done_o;
    logic                 partial_results_valid_o;

    modport master (
        output load_i, vl_i, vstart_i, vm_i, shift_en_i, mask_i, shift_partial_i,
        input  valid_o, tail_o, last_o, busy_o, done_o, partial_results_valid_o
    );

    modport slave (
        input  load_i, vl_i, vstart_i, vm_i, shift_en_i, mask_i, shift_partial_i,
        output valid_o, tail_o, last_o, busy_o, done_o, partial_results_valid_o
    );
endinterface

// File: rtl/v_elem_valid_gen.sv
// Per-lane element-valid generator: walks the rows of one vector instruction and
// flags body/tail elements per lane, plus the reduction partial-result valid chain.
module v_elem_valid_gen #(
    parameter int VLANE_NUM       = 8,
    parameter int MAX_VL_PER_LANE = 256
) (
    input logic               clk_i,
    input logic               rst_i,
    v_elem_valid_gen_if.slave bus
);
    localparam int VL_W   = $clog2(VLANE_NUM * MAX_VL_PER_LANE) + 1;
    localparam int E_W    = VL_W + 1;
    localparam int LANE_W = $clog2(VLANE_NUM);
    localparam int ROW_W  = $clog2(MAX_VL_PER_LANE);
    localparam logic [VL_W-1:0] MAX_VL = VL_W'(VLANE_NUM * MAX_VL_PER_LANE);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state_q, state_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic                   done_q, done_d;
    logic [VL_W-1:0]        vl_q, vstart_q;
    logic                   vm_q;
    logic [VLANE_NUM-2:0]   pr_q, pr_load;

    logic [VL_W-1:0]        vl_clamped, vl_in_m1, vl_q_m1, n_elems;
    logic                   has_elems;
    logic [ROW_W-1:0]       start_row, last_row;
    logic                   busy, advance, at_last;
    logic [LANE_W-1:0]      lane_lo, lane_hi;

    // Incoming instruction decode; only meaningful in the load cycle.
    assign vl_clamped = (bus.vl_i > MAX_VL) ? MAX_VL : bus.vl_i;
    assign has_elems  = bus.vstart_i < vl_clamped;
    assign vl_in_m1   = vl_clamped - 1'b1;
    assign n_elems    = vl_clamped - bus.vstart_i;
    assign start_row  = bus.vstart_i[LANE_W +: ROW_W];
    assign lane_lo    = bus.vstart_i[LANE_W-1:0];
    assign lane_hi    = vl_in_m1[LANE_W-1:0];

    assign vl_q_m1  = vl_q - 1'b1;
    assign last_row = vl_q_m1[LANE_W +: ROW_W];
    assign busy     = (state_q == RUN);
    assign advance  = bus.shift_en_i & busy;
    assign at_last  = (row_q == last_row);

    // Lanes 1..N-1 that receive at least one body element of the instruction.
    always_comb begin
        pr_load = '0;
        if (has_elems) begin
            if (n_elems >= VL_W'(VLANE_NUM)) begin
                pr_load = '1;
            end else begin
                for (int i = 0; i < VLANE_NUM - 1; i++) begin
                    if (lane_lo <= lane_hi)
                        pr_load[i] = (LANE_W'(i + 1) >= lane_lo) && (LANE_W'(i + 1) <= lane_hi);
                    else
                        pr_load[i] = (LANE_W'(i + 1) >= lane_lo) || (LANE_W'(i + 1) <= lane_hi);
                end
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        done_d  = 1'b0;
        if (bus.load_i) begin
            if (has_elems) begin
                state_d = RUN;
                row_d   = start_row;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end else if (advance) begin
            if (at_last) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                row_d = row_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            row_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vl_q     <= '0;
            vstart_q <= '0;
            vm_q     <= 1'b0;
            pr_q     <= '0;
        end else if (bus.load_i) begin
            vl_q     <= vl_clamped;
            vstart_q <= bus.vstart_i;
            vm_q     <= bus.vm_i;
            pr_q     <= pr_load;
        end else if (!advance && bus.shift_partial_i) begin
            pr_q <= pr_q >> 1;
        end
    end

    // Element index is widened by one bit so the compare against vl never wraps.
    always_comb begin
        bus.valid_o = '0;
        bus.tail_o  = '0;
        for (int l = 0; l < VLANE_NUM; l++) begin
            logic [E_W-1:0] e;
            e = E_W'({row_q, LANE_W'(l)});
            bus.valid_o[l] = advance && (e >= E_W'(vstart_q)) && (e < E_W'(vl_q))
                             && (vm_q || bus.mask_i[l]);
            bus.tail_o[l]  = advance && (e >= E_W'(vl_q));
        end
    end

    assign bus.last_o                  = advance & at_last;
    assign bus.busy_o                  = busy;
    assign bus.done_o                  = done_q;
    assign bus.partial_results_valid_o = pr_q[0];
endmodule

// File: tb/tb_v_elem_valid_gen.sv
// Self-checking bench for v_elem_valid_gen: directed scenarios plus randomized
// instructions compared against an element-set reference model.
module tb_v_elem_valid_gen;
    localparam int N    = 8;
    localparam int M    = 256;
    localparam int VL_W = $clog2(N * M) + 1;
    localparam int MAXV = N * M;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    v_elem_valid_gen_if #(.VLANE_NUM(N), .MAX_VL_PER_LANE(M)) bus ();

    v_elem_valid_gen #(.VLANE_NUM(N), .MAX_VL_PER_LANE(M)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input bit ok, input string msg);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s", msg);
        end
    endtask

    // Reference model: element k of the instruction sits in row k/N, lane k%N.
    function automatic int clamp_vl(input int vl);
        return (vl > MAXV) ? MAXV : vl;
    endfunction

    function automatic logic [N-1:0] m_valid(input int row, input int vl, input int vs,
                                             input bit vm, input logic [N-1:0] mask);
        logic [N-1:0] r;
        r = '0;
        for (int l = 0; l < N; l++) begin
            int k;
            k = row * N + l;
            r[l] = (k >= vs) && (k < vl) && (vm || mask[l]);
        end
        return r;
    endfunction

    function automatic logic [N-1:0] m_tail(input int row, input int vl);
        logic [N-1:0] r;
        r = '0;
        for (int l = 0; l < N; l++) r[l] = (row * N + l) >= vl;
        return r;
    endfunction

    // Bit i of the chain is set when lane i+1 holds any body element.
    function automatic logic [N-1:0] m_pr(input int vl, input int vs);
        logic [N-1:0] r;
        r = '0;
        if (vs >= vl) return r;
        if (vl - vs >= N) return {1'b0, {(N-1){1'b1}}};
        for (int k = vs; k < vl; k++) if ((k % N) != 0) r[(k % N) - 1] = 1'b1;
        return r;
    endfunction

    task automatic idle_inputs();
        bus.load_i          = 1'b0;
        bus.vl_i            = '0;
        bus.vstart_i        = '0;
        bus.vm_i            = 1'b0;
        bus.shift_en_i      = 1'b0;
        bus.mask_i          = '0;
        bus.shift_partial_i = 1'b0;
    endtask

    // Loads one instruction and walks every row, comparing all outputs each cycle.
    task automatic run_instr(input string name, input int vl_in, input int vs, input bit vm,
                             input bit rand_mask, input logic [N-1:0] fixed_mask,
                             input bit gaps, input bit chain);
        int           vl;
        logic [N-1:0] epr, mk, ev, et;
        bit           el;
        vl  = clamp_vl(vl_in);
        epr = m_pr(vl, vs);
        @(negedge clk);
        bus.load_i     = 1'b1;
        bus.vl_i       = VL_W'(vl_in);
        bus.vstart_i   = VL_W'(vs);
        bus.vm_i       = vm;
        bus.shift_en_i = 1'b0;
        @(negedge clk);
        bus.load_i = 1'b0;
        #1;
        if (vs >= vl) begin
            check(bus.busy_o === 1'b0 && bus.done_o === 1'b1,
                  $sformatf("%s empty-load: busy=%b done=%b expected busy=0 done=1",
                            name, bus.busy_o, bus.done_o));
            @(negedge clk); #1;
            check(bus.busy_o === 1'b0 && bus.done_o === 1'b0,
                  $sformatf("%s empty-after: busy=%b done=%b expected busy=0 done=0",
                            name, bus.busy_o, bus.done_o));
        end else begin
            check(bus.busy_o === 1'b1 && bus.done_o === 1'b0,
                  $sformatf("%s load: busy=%b done=%b expected busy=1 done=0",
                            name, bus.busy_o, bus.done_o));
            for (int r = vs / N; r <= (vl - 1) / N; r++) begin
                if (gaps && $urandom_range(3) == 0) begin
                    bus.shift_en_i = 1'b0;
                    bus.mask_i     = N'($urandom);
                    #1;
                    check({bus.valid_o, bus.tail_o, bus.last_o, bus.busy_o} === {{(2*N){1'b0}}, 2'b01},
                          $sformatf("%s gap row %0d: valid=%h tail=%h last=%b busy=%b expected 0/0/0/1",
                                    name, r, bus.valid_o, bus.tail_o, bus.last_o, bus.busy_o));
                    @(negedge clk);
                end
                mk = rand_mask ? N'($urandom) : fixed_mask;
                bus.shift_en_i = 1'b1;
                bus.mask_i     = mk;
                #1;
                ev = m_valid(r, vl, vs, vm, mk);
                et = m_tail(r, vl);
                el = (r == (vl - 1) / N);
                check(bus.valid_o === ev && bus.tail_o === et && bus.last_o === el,
                      $sformatf("%s row %0d: valid=%h tail=%h last=%b expected valid=%h tail=%h last=%b",
                                name, r, bus.valid_o, bus.tail_o, bus.last_o, ev, et, el));
                @(negedge clk);
                bus.shift_en_i = 1'b0;
            end
            #1;
            check(bus.done_o === 1'b1 && bus.busy_o === 1'b0,
                  $sformatf("%s done: done=%b busy=%b expected done=1 busy=0",
                            name, bus.done_o, bus.busy_o));
            @(negedge clk); #1;
            check(bus.done_o === 1'b0,
                  $sformatf("%s done-width: done=%b expected 0", name, bus.done_o));
        end
        if (chain) begin
            for (int k = 0; k < N; k++) begin
                check(bus.partial_results_valid_o === epr[k],
                      $sformatf("%s chain step %0d: prv=%b expected %b",
                                name, k, bus.partial_results_valid_o, epr[k]));
                @(negedge clk);
                bus.shift_partial_i = 1'b1;
                @(negedge clk);
                bus.shift_partial_i = 1'b0;
                #1;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        bus.shift_en_i = 1'b1;
        bus.mask_i     = '1;
        #12;
        check({bus.valid_o, bus.tail_o, bus.last_o, bus.busy_o, bus.done_o,
               bus.partial_results_valid_o} === '0,
              $sformatf("reset outputs: valid=%h tail=%h last=%b busy=%b done=%b prv=%b expected all 0",
                        bus.valid_o, bus.tail_o, bus.last_o, bus.busy_o, bus.done_o,
                        bus.partial_results_valid_o));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check({bus.valid_o, bus.tail_o, bus.last_o, bus.busy_o, bus.done_o} === '0,
              $sformatf("idle shift: valid=%h tail=%h last=%b busy=%b done=%b expected all 0",
                        bus.valid_o, bus.tail_o, bus.last_o, bus.busy_o, bus.done_o));
        bus.shift_en_i = 1'b0;
    endtask

    task automatic test_tail_row();
        run_instr("tail_row", 19, 0, 1'b1, 1'b1, '0, 1'b0, 1'b1);
    endtask

    task automatic test_partial_chain();
        run_instr("partial_chain", 5, 0, 1'b1, 1'b1, '0, 1'b0, 1'b1);
    endtask

    task automatic test_vstart();
        run_instr("vstart", 20, 10, 1'b1, 1'b1, '0, 1'b0, 1'b1);
    endtask

    task automatic test_masking();
        run_instr("mask_vm0", 8, 0, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b0);
        run_instr("mask_vm1", 8, 0, 1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
    endtask

    task automatic test_boundaries();
        run_instr("vl0", 0, 0, 1'b1, 1'b1, '0, 1'b0, 1'b1);
        run_instr("vstart_ge_vl", 16, 16, 1'b1, 1'b1, '0, 1'b0, 1'b0);
        run_instr("vl_max", 2048, 0, 1'b1, 1'b1, '0, 1'b0, 1'b0);
        run_instr("vl_clamp", 3000, 0, 1'b1, 1'b1, '0, 1'b0, 1'b1);
    endtask

    task automatic test_restart();
        logic [N-1:0] ev, et;
        @(negedge clk);
        bus.load_i = 1'b1; bus.vl_i = VL_W'(64); bus.vstart_i = '0; bus.vm_i = 1'b1;
        @(negedge clk);
        bus.load_i = 1'b0; bus.shift_en_i = 1'b1; bus.mask_i = '1;
        @(negedge clk);
        @(negedge clk);
        bus.load_i = 1'b1; bus.vl_i = VL_W'(19); bus.vstart_i = VL_W'(8);
        @(negedge clk);
        bus.load_i = 1'b0; bus.shift_en_i = 1'b0;
        #1;
        check(bus.busy_o === 1'b1 && bus.done_o === 1'b0 && bus.partial_results_valid_o === 1'b1,
              $sformatf("restart load: busy=%b done=%b prv=%b expected busy=1 done=0 prv=1",
                        bus.busy_o, bus.done_o, bus.partial_results_valid_o));
        for (int r = 1; r <= 2; r++) begin
            bus.shift_en_i = 1'b1;
            bus.mask_i     = N'($urandom);
            #1;
            ev = m_valid(r, 19, 8, 1'b1, bus.mask_i);
            et = m_tail(r, 19);
            check(bus.valid_o === ev && bus.tail_o === et && bus.last_o === (r == 2),
                  $sformatf("restart row %0d: valid=%h tail=%h last=%b expected valid=%h tail=%h last=%b",
                            r, bus.valid_o, bus.tail_o, bus.last_o, ev, et, (r == 2)));
            @(negedge clk);
            bus.shift_en_i = 1'b0;
        end
        #1;
        check(bus.done_o === 1'b1 && bus.busy_o === 1'b0,
              $sformatf("restart done: done=%b busy=%b expected done=1 busy=0",
                        bus.done_o, bus.busy_o));
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        bus.load_i = 1'b1; bus.vl_i = VL_W'(64); bus.vstart_i = '0; bus.vm_i = 1'b1;
        @(negedge clk);
        bus.load_i = 1'b0; bus.shift_en_i = 1'b1; bus.mask_i = '1;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check({bus.busy_o, bus.valid_o, bus.tail_o, bus.last_o, bus.partial_results_valid_o} === '0,
              $sformatf("async reset: busy=%b valid=%h tail=%h last=%b prv=%b expected all 0",
                        bus.busy_o, bus.valid_o, bus.tail_o, bus.last_o,
                        bus.partial_results_valid_o));
        bus.shift_en_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            check(bus.done_o === 1'b0 && bus.busy_o === 1'b0,
                  $sformatf("post-reset cycle %0d: done=%b busy=%b expected 0/0",
                            c, bus.done_o, bus.busy_o));
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            int vl, vs;
            vl = ($urandom_range(4) == 0) ? int'($urandom_range(3000)) : int'($urandom_range(100));
            vs = int'($urandom_range(clamp_vl(vl) + 4));
            run_instr("random", vl, vs, 1'($urandom), 1'b1, '0, 1'b1, 1'b1);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_tail_row();
        test_partial_chain();
        test_vstart();
        test_masking();
        test_boundaries();
        test_restart();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/v_elem_valid_gen.md
# v_elem_valid_gen

Per-lane element-valid generator for the vector control unit, successor to the single-mode validity tracker. For each row of elements issued to the lanes, it produces per-lane body-valid and tail flags. It honours `vstart` (prestart skipping), `vl` (tail) and an optional per-row mask. It also provides a last-row flag, a completion pulse and the per-lane partial-result valid chain used by reduction shifting. It sits between the vector issue FSM and the lane write-enable / reduction logic.

## Interface
Parameters:
- `VLANE_NUM`, 8: lane count, power of two, ≥2.
- `MAX_VL_PER_LANE`, 256: maximum elements per lane (rows), power of two.
- Derived `VL_W` = `$clog2(VLANE_NUM*MAX_VL_PER_LANE)+1`, so full `vl` is representable.

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `load_i`  in  1  capture `vl_i`, `vstart_i`, `vm_i`; start a new instruction.
- `vl_i`  in  `VL_W`  vector length; values above `VLANE_NUM*MAX_VL_PER_LANE` clamp to max.
- `vstart_i`  in  `VL_W`  first body element index.
- `vm_i`  in  1  1 = unmasked; 0 = apply `mask_i`.
- `shift_en_i`  in  1  current row is issued this cycle; advance.
- `mask_i`  in  `VLANE_NUM`  mask bits for the current row, sampled with `shift_en_i`.
- `shift_partial_i`  in  1  shift partial-result valid chain by one lane.
- `valid_o`  out  `VLANE_NUM`  body element active and enabled, per lane.
- `tail_o`  out  `VLANE_NUM`  element index ≥ vl, per lane.
- `last_o`  out  1  current shifted row is the final row.
- `busy_o`  out  1  instruction in progress.
- `done_o`  out  1  one-cycle completion pulse.
- `partial_results_valid_o`  out  1  bit 0 of partial chain (lane 1 result valid).

## Operation
- Latched state: `vl_q`, `vstart_q`, `vm_q`, row counter `row` (`$clog2(MAX_VL_PER_LANE)` bits), `last_row = (vl_q-1) >> log2(VLANE_NUM)`, partial chain `pr` (`VLANE_NUM-1` bits).
- Element index `e = row*VLANE_NUM + l`, computed in `VL_W+1` bits with no wrap.
- FSM states:
  - IDLE: on `load_i` with `vstart < vl`, go to RUN and set `row = vstart >> log2(VLANE_NUM)`. On `load_i` with `vstart ≥ vl` (incl. `vl=0`), stay IDLE and pulse `done_o` next cycle.
  - RUN: on `shift_en_i`, if `row == last_row`, go to IDLE and pulse `done_o` next cycle; otherwise `row++`.
- Per-lane outputs, combinational, gated by `shift_en_i & busy_o`:
  - `valid_o[l] = (vstart_q ≤ e < vl_q) & (vm_q | mask_i[l])`.
  - `tail_o[l] = e ≥ vl_q`.
  - Prestart elements assert neither flag.
- `last_o = shift_en_i & busy_o & (row == last_row)`.
- Partial chain on load, with `n = vl - vstart`:
  - `n ≥ VLANE_NUM`: `pr` = all ones.
  - `n = 0`: `pr = 0`.
  - Otherwise, bit `i` = 1 iff lane `i+1` lies in the lane range `[vstart mod N, (vl-1) mod N]`, wrapping modulo N.
  - Mask does not affect `pr`.
- On `shift_partial_i`: `pr <= pr >> 1`, filling the MSB with 0.
- Priority: `load_i` > `shift_en_i` > `shift_partial_i`.
  - `load_i` while RUN restarts cleanly and discards the old instruction; no `done_o` for it.
- `shift_en_i` in IDLE: all outputs 0, no state change.

## Timing
- Reset (async, immediate): IDLE, `row=0`, `pr=0`, latched regs 0. All outputs 0.
- `busy_o` is registered: high the cycle after `load_i`, low the cycle after the final shift.
- `valid_o`, `tail_o`, `last_o` have zero latency relative to `shift_en_i` and use the pre-edge `row`.
- `done_o` is registered, exactly one cycle, the cycle after the final shift, or the cycle after a no-element load.
- `partial_results_valid_o` reflects `pr[0]` from the cycle after load or shift.
- Reset asserted mid-RUN: outputs drop asynchronously; no `done_o` after release.

## Test plan
- **Tail row.** `vl=19`, `vstart=0`, `vm=1`, shift every cycle.
  - Rows 0, 1: `valid=FF`.
  - Row 2: `valid=07`, `tail=F8`, `last_o=1`.
  - `done_o` the next cycle; `pr=7F`.
- **Partial chain.** `vl=5`.
  - After load: `pr=0F`.
  - Five `shift_partial_i`: `partial_results_valid_o` = 1,1,1,1,0.
- **vstart skipping.** `vstart=10`, `vl=20`.
  - First shift is row 1: `valid=FC`.
  - Row 2: `valid=0F`, `tail=F0`, `last_o=1`.
  - `pr=7F`.
- **Masking.** `vm=0`, `vl=8`, `mask_i=AA`.
  - `valid=AA`, `last_o=1`.
  - Same with `vm=1`: `valid=FF`.
- **Boundaries.**
  - `vl=0`: `busy_o` never rises; `done_o` pulses the cycle after load.
  - `vl=2048`: 256 rows of `FF`, `last_o` on row 255.
  - `vl=3000` clamps to 2048.
- **Interruptions.**
  - `load_i` with `shift_en_i` mid-RUN: restart wins, `row` is reinitialised, no `done_o` for the old instruction.
  - `rst_i` low mid-RUN: `busy_o=0` without a clock edge.
